// File: rtl/reorder_buffer.sv
// Reorder buffer: tag allocation, CDB capture, operand lookup
// and strictly in-order retirement of the Tomasulo core.
module reorder_buffer #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int Q_WIDTH        = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      issue_valid,
    input  logic                      issue_has_rd,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic                      issue_ready,
    output logic [Q_WIDTH-1:0]        issue_tag,
    output logic                      rd_control,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic [Q_WIDTH-1:0]        Q_value,
    input  logic                      cdb_valid,
    input  logic [Q_WIDTH-1:0]        cdb_tag,
    input  logic [31:0]               cdb_value,
    input  logic [Q_WIDTH-1:0]        query1_tag,
    input  logic [Q_WIDTH-1:0]        query2_tag,
    output logic                      query1_ready,
    output logic                      query2_ready,
    output logic [31:0]               query1_value,
    output logic [31:0]               query2_value,
    output logic                      has_commit,
    output logic [REG_ADDR_WIDTH-1:0] commit_target,
    output logic [Q_WIDTH-1:0]        Commit_Q,
    output logic [31:0]               Commit_V
);

    localparam int NENT = 2 ** Q_WIDTH;
    localparam int ROB_SIZE = NENT - 1;
    localparam logic [Q_WIDTH-1:0] LAST = Q_WIDTH'(ROB_SIZE);
    localparam logic [Q_WIDTH-1:0] FIRST = Q_WIDTH'(1);

    logic [Q_WIDTH-1:0]        head_q, head_d;
    logic [Q_WIDTH-1:0]        tail_q, tail_d;
    logic [Q_WIDTH-1:0]        count_q, count_d;
    logic [NENT-1:0]           busy_q, busy_d;
    logic [NENT-1:0]           ready_q, ready_d;
    logic [REG_ADDR_WIDTH-1:0] dest_q [NENT];
    logic [REG_ADDR_WIDTH-1:0] dest_d [NENT];
    logic [31:0]               value_q [NENT];
    logic [31:0]               value_d [NENT];

    logic                      has_commit_q, has_commit_d;
    logic [REG_ADDR_WIDTH-1:0] commit_target_q, commit_target_d;
    logic [Q_WIDTH-1:0]        commit_q_q, commit_q_d;
    logic [31:0]               commit_v_q, commit_v_d;

    logic issue_fire;
    logic commit_fire;
    logic cdb_hit;

    // Tag 0 means "no producer", so the ring skips it.
    function automatic logic [Q_WIDTH-1:0] tag_inc(
        input logic [Q_WIDTH-1:0] t
    );
        return (t == LAST) ? FIRST : t + FIRST;
    endfunction

    function automatic logic lookup_ready(
        input logic [Q_WIDTH-1:0] t,
        input logic [NENT-1:0]    rdy,
        input logic               cv,
        input logic [Q_WIDTH-1:0] ct
    );
        if (t == '0) return 1'b0;
        if (rdy[t]) return 1'b1;
        return cv && (ct == t);
    endfunction

    assign issue_ready = rdy_in && (count_q != LAST);
    assign issue_fire  = issue_valid && issue_ready;
    assign issue_tag   = tail_q;
    assign rd_control  = issue_fire && issue_has_rd &&
                         (issue_rd != '0);
    assign rd          = issue_rd;
    assign Q_value     = tail_q;

    assign commit_fire = rdy_in && busy_q[head_q] && ready_q[head_q];
    assign cdb_hit     = rdy_in && cdb_valid && (cdb_tag != '0) &&
                         busy_q[cdb_tag];

    always_comb begin
        query1_ready = lookup_ready(query1_tag, ready_q,
                                    cdb_valid, cdb_tag);
        query2_ready = lookup_ready(query2_tag, ready_q,
                                    cdb_valid, cdb_tag);
        query1_value = '0;
        query2_value = '0;
        if (query1_ready)
            query1_value = ready_q[query1_tag] ?
                           value_q[query1_tag] : cdb_value;
        if (query2_ready)
            query2_value = ready_q[query2_tag] ?
                           value_q[query2_tag] : cdb_value;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        dest_d  = dest_q;
        value_d = value_q;

        has_commit_d    = commit_fire;
        commit_target_d = commit_target_q;
        commit_q_d      = commit_q_q;
        commit_v_d      = commit_v_q;

        if (cdb_hit) begin
            ready_d[cdb_tag] = 1'b1;
            value_d[cdb_tag] = cdb_value;
        end

        if (commit_fire) begin
            commit_target_d = dest_q[head_q];
            commit_q_d      = head_q;
            commit_v_d      = value_q[head_q];
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            dest_d[head_q]  = '0;
            value_d[head_q] = '0;
            head_d          = tag_inc(head_q);
        end

        if (issue_fire) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            dest_d[tail_q]  = issue_has_rd ? issue_rd : '0;
            tail_d          = tag_inc(tail_q);
        end

        unique case ({issue_fire, commit_fire})
            2'b10:   count_d = count_q + FIRST;
            2'b01:   count_d = count_q - FIRST;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q          <= FIRST;
            tail_q          <= FIRST;
            count_q         <= '0;
            busy_q          <= '0;
            ready_q         <= '0;
            has_commit_q    <= 1'b0;
            commit_target_q <= '0;
            commit_q_q      <= '0;
            commit_v_q      <= '0;
            for (int i = 0; i < NENT; i++) begin
                dest_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            busy_q          <= busy_d;
            ready_q         <= ready_d;
            has_commit_q    <= has_commit_d;
            commit_target_q <= commit_target_d;
            commit_q_q      <= commit_q_d;
            commit_v_q      <= commit_v_d;
            for (int i = 0; i < NENT; i++) begin
                dest_q[i]  <= dest_d[i];
                value_q[i] <= value_d[i];
            end
        end
    end

    assign has_commit    = has_commit_q;
    assign commit_target = commit_target_q;
    assign Commit_Q      = commit_q_q;
    assign Commit_V      = commit_v_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill, retire order,
// wrap, CDB bypass, stall and mid-stream reset.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic        issue_has_rd;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [3:0]  issue_tag;
    logic        rd_control;
    logic [4:0]  rd;
    logic [3:0]  Q_value;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [3:0]  query1_tag, query2_tag;
    logic        query1_ready, query2_ready;
    logic [31:0] query1_value, query2_value;
    logic        has_commit;
    logic [4:0]  commit_target;
    logic [3:0]  Commit_Q;
    logic [31:0] Commit_V;

    int checks = 0;
    int errors = 0;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_has_rd(issue_has_rd),
        .issue_rd(issue_rd), .issue_ready(issue_ready),
        .issue_tag(issue_tag), .rd_control(rd_control),
        .rd(rd), .Q_value(Q_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value),
        .query1_tag(query1_tag), .query2_tag(query2_tag),
        .query1_ready(query1_ready), .query2_ready(query2_ready),
        .query1_value(query1_value), .query2_value(query2_value),
        .has_commit(has_commit), .commit_target(commit_target),
        .Commit_Q(Commit_Q), .Commit_V(Commit_V)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1;
        issue_valid = 0; issue_has_rd = 0; issue_rd = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
        query1_tag = 0; query2_tag = 0;
        step(); step();
        rst_in = 1'b0;
        #1;
        checks++;
        if (issue_ready !== 1'b1 || issue_tag !== 4'd1) begin
            errors++;
            $display("FAIL reset_issue: ready=%b tag=%0d want 1/1",
                     issue_ready, issue_tag);
        end
        checks++;
        if (has_commit !== 1'b0 || commit_target !== 5'd0 ||
            Commit_Q !== 4'd0 || Commit_V !== 32'd0) begin
            errors++;
            $display("FAIL reset_commit: hc=%b t=%0d q=%0d v=%h want 0",
                     has_commit, commit_target, Commit_Q, Commit_V);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 15; i++) begin
            issue_valid = 1; issue_has_rd = 1; issue_rd = 5'(i);
            #1;
            checks++;
            if (issue_tag !== 4'(i) || rd_control !== 1'b1 ||
                Q_value !== 4'(i) || issue_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_%0d: tag=%0d rc=%b q=%0d rdy=%b want tag %0d",
                         i, issue_tag, rd_control, Q_value,
                         issue_ready, i);
            end
            step();
        end
        issue_rd = 5'd16;
        #1;
        checks++;
        if (issue_ready !== 1'b0 || rd_control !== 1'b0) begin
            errors++;
            $display("FAIL full_block: rdy=%b rc=%b want 0/0",
                     issue_ready, rd_control);
        end
        step();
        issue_valid = 0;
        #1;
        checks++;
        if (issue_tag !== 4'd1 || issue_ready !== 1'b0 ||
            has_commit !== 1'b0) begin
            errors++;
            $display("FAIL full_ignored: tag=%0d rdy=%b hc=%b want 1/0/0",
                     issue_tag, issue_ready, has_commit);
        end
    endtask

    task automatic test_full_commit();
        cdb_valid = 1; cdb_tag = 4'd1; cdb_value = 32'hA5;
        step();
        cdb_valid = 0;
        #1;
        checks++;
        if (has_commit !== 1'b0 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL cdb_no_bypass: hc=%b rdy=%b want 0/0",
                     has_commit, issue_ready);
        end
        step();
        checks++;
        if (has_commit !== 1'b1 || commit_target !== 5'd1 ||
            Commit_Q !== 4'd1 || Commit_V !== 32'hA5 ||
            issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_commit: hc=%b t=%0d q=%0d v=%h rdy=%b want 1/1/1/a5/1",
                     has_commit, commit_target, Commit_Q, Commit_V,
                     issue_ready);
        end
        step();
        checks++;
        if (has_commit !== 1'b0) begin
            errors++;
            $display("FAIL commit_pulse: hc=%b want 0", has_commit);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_has_rd = 1; issue_rd = 5'(5 + i);
            step();
        end
        issue_valid = 0;
        for (int k = 0; k < 7; k++) begin
            if (k < 3) begin
                cdb_valid = 1; cdb_tag = 4'(3 - k);
                cdb_value = 32'h100 + 32'(3 - k);
            end else begin
                cdb_valid = 0;
            end
            step();
            checks++;
            if (k >= 3 && k <= 5) begin
                if (has_commit !== 1'b1 || Commit_Q !== 4'(k - 2) ||
                    commit_target !== 5'(k + 2) ||
                    Commit_V !== 32'h100 + 32'(k - 2)) begin
                    errors++;
                    $display("FAIL order_%0d: hc=%b q=%0d t=%0d v=%h want q %0d",
                             k, has_commit, Commit_Q, commit_target,
                             Commit_V, k - 2);
                end
            end else if (has_commit !== 1'b0) begin
                errors++;
                $display("FAIL order_idle_%0d: hc=%b want 0",
                         k, has_commit);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_q;
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            issue_valid = 1; issue_has_rd = 1; issue_rd = 5'(i);
            step();
        end
        issue_valid = 0;
        exp_q = 1;
        for (int c = 1; c <= 17; c++) begin
            if (c <= 14) begin
                cdb_valid = 1; cdb_tag = 4'(c);
                cdb_value = 32'(c) << 4;
            end else begin
                cdb_valid = 0;
            end
            step();
            if (has_commit === 1'b1) begin
                checks++;
                if (Commit_Q !== 4'(exp_q) ||
                    commit_target !== 5'(exp_q) ||
                    Commit_V !== (32'(exp_q) << 4)) begin
                    errors++;
                    $display("FAIL wrap_commit: q=%0d t=%0d v=%h want q %0d",
                             Commit_Q, commit_target, Commit_V, exp_q);
                end
                exp_q++;
            end
        end
        checks++;
        if (exp_q !== 15 || issue_tag !== 4'd15) begin
            errors++;
            $display("FAIL wrap_drain: commits=%0d tag=%0d want 14/15",
                     exp_q - 1, issue_tag);
        end
        issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd9;
        #1;
        checks++;
        if (rd_control !== 1'b1 || Q_value !== 4'd15 ||
            rd !== 5'd9) begin
            errors++;
            $display("FAIL wrap_15: rc=%b q=%0d rd=%0d want 1/15/9",
                     rd_control, Q_value, rd);
        end
        step();
        issue_has_rd = 0;
        #1;
        checks++;
        if (issue_tag !== 4'd1 || Q_value !== 4'd1 ||
            rd_control !== 1'b0) begin
            errors++;
            $display("FAIL wrap_1: tag=%0d q=%0d rc=%b want 1/1/0",
                     issue_tag, Q_value, rd_control);
        end
        step();
        issue_has_rd = 1; issue_rd = 5'd0;
        #1;
        checks++;
        if (issue_tag !== 4'd2 || rd_control !== 1'b0) begin
            errors++;
            $display("FAIL rd_zero: tag=%0d rc=%b want 2/0",
                     issue_tag, rd_control);
        end
        step();
        issue_valid = 0;
    endtask

    task automatic test_query();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            issue_valid = 1; issue_has_rd = 1; issue_rd = 5'(10 + i);
            step();
        end
        issue_valid = 0;
        cdb_valid = 1; cdb_tag = 4'd2; cdb_value = 32'h1234;
        query1_tag = 4'd1; query2_tag = 4'd2;
        #1;
        checks++;
        if (query2_ready !== 1'b1 || query2_value !== 32'h1234 ||
            query1_ready !== 1'b0 || query1_value !== 32'd0) begin
            errors++;
            $display("FAIL query_bypass: q2=%b/%h q1=%b/%h want 1/1234 0/0",
                     query2_ready, query2_value,
                     query1_ready, query1_value);
        end
        step();
        cdb_valid = 0; query1_tag = 4'd0;
        #1;
        checks++;
        if (query2_ready !== 1'b1 || query2_value !== 32'h1234 ||
            query1_ready !== 1'b0 || has_commit !== 1'b0) begin
            errors++;
            $display("FAIL query_stored: q2=%b/%h q1=%b hc=%b want 1/1234 0 0",
                     query2_ready, query2_value, query1_ready,
                     has_commit);
        end
    endtask

    task automatic test_stall();
        cdb_valid = 1; cdb_tag = 4'd1; cdb_value = 32'h77;
        step();
        cdb_valid = 0;
        rdy_in = 0; issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd4;
        query1_tag = 4'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (issue_ready !== 1'b0 || rd_control !== 1'b0 ||
                query1_ready !== 1'b1 || query1_value !== 32'h77) begin
                errors++;
                $display("FAIL stall_%0d: rdy=%b rc=%b q1=%b/%h want 0/0/1/77",
                         i, issue_ready, rd_control, query1_ready,
                         query1_value);
            end
            step();
            checks++;
            if (has_commit !== 1'b0) begin
                errors++;
                $display("FAIL stall_commit_%0d: hc=%b want 0",
                         i, has_commit);
            end
        end
        rdy_in = 1; issue_valid = 0;
        step();
        checks++;
        if (has_commit !== 1'b1 || Commit_Q !== 4'd1 ||
            Commit_V !== 32'h77 || commit_target !== 5'd10) begin
            errors++;
            $display("FAIL resume_1: hc=%b q=%0d v=%h t=%0d want 1/1/77/10",
                     has_commit, Commit_Q, Commit_V, commit_target);
        end
        step();
        checks++;
        if (has_commit !== 1'b1 || Commit_Q !== 4'd2 ||
            Commit_V !== 32'h1234 || issue_tag !== 4'd3) begin
            errors++;
            $display("FAIL resume_2: hc=%b q=%0d v=%h tag=%0d want 1/2/1234/3",
                     has_commit, Commit_Q, Commit_V, issue_tag);
        end
    endtask

    task automatic test_reset_mid();
        issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd8;
        step();
        issue_valid = 0;
        cdb_valid = 1; cdb_tag = 4'd3; cdb_value = 32'hBEEF;
        step();
        cdb_valid = 0;
        rst_in = 1;
        step();
        rst_in = 0;
        query1_tag = 4'd3;
        #1;
        checks++;
        if (has_commit !== 1'b0 || issue_tag !== 4'd1 ||
            issue_ready !== 1'b1 || query1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: hc=%b tag=%0d rdy=%b q1=%b want 0/1/1/0",
                     has_commit, issue_tag, issue_ready, query1_ready);
        end
        step();
        checks++;
        if (has_commit !== 1'b0 || Commit_Q !== 4'd0) begin
            errors++;
            $display("FAIL reset_after: hc=%b q=%0d want 0/0",
                     has_commit, Commit_Q);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_commit();
        test_in_order();
        test_wrap();
        test_query();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
